keypad_debounce_encoder: RTL and testbench

- Upstream front end of the door-lock datapath, between the ten raw push-button inputs (digits 0-9) and the digit shift registers and password comparator.
- Synchronises and debounces the buttons, then encodes each press as a 4-bit digit code with a one-cycle strobe.
- Counts digits toward a 4-digit entry and signals entry completion.
- Drives a timed beep-enable for the piezo divider, replacing the raw OR-of-buttons clock enable.

---
 rtl/keypad_debounce_encoder_pkg.sv | 20 ++
 rtl/keypad_debounce_encoder_if.sv | 13 +
 rtl/keypad_debounce_encoder_key_sync.sv | 21 ++
 rtl/keypad_debounce_encoder.sv | 94 +++++++++
 tb/tb_keypad_debounce_encoder.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_debounce_encoder_pkg.sv
// keypad_debounce_encoder_pkg: shared states, constants and one-hot key encoder
package keypad_debounce_encoder_pkg;
  localparam int NUM_KEYS = 10;
  localparam logic [3:0] KEY_NONE = 4'hF;
  typedef enum logic [1:0] {IDLE, SETTLE, HELD, RELEASE} state_t;
  typedef struct packed {
    logic       ok;
    logic [3:0] idx;
  } onehot_t;
  function automatic onehot_t onehot_enc(input logic [NUM_KEYS-1:0] v);
    logic [3:0] n;
    n = '0;
    onehot_enc = '{ok: 1'b0, idx: KEY_NONE};
    for (int i = 0; i < NUM_KEYS; i++) begin
      n = n + 4'(v[i]);
      if (v[i]) onehot_enc.idx = 4'(i);
    end
    onehot_enc.ok = (n == 4'd1);
  endfunction
endpackage

// File: rtl/keypad_debounce_encoder_if.sv
// keypad_debounce_encoder_if: raw keys and clear in, encoded key events and beep out
interface keypad_debounce_encoder_if import keypad_debounce_encoder_pkg::*; ();
  logic [NUM_KEYS-1:0] key_in;
  logic                clr;
  logic                key_valid;
  logic [3:0]          key_code;
  logic [2:0]          digit_cnt;
  logic                entry_done;
  logic                multi_key_err;
  logic                beep_en;
  modport master(output key_in, clr, input key_valid, key_code, digit_cnt, entry_done, multi_key_err, beep_en);
  modport slave(input key_in, clr, output key_valid, key_code, digit_cnt, entry_done, multi_key_err, beep_en);
endinterface

// File: rtl/keypad_debounce_encoder_key_sync.sv
// key_sync: two-flop synchroniser for a vector of asynchronous inputs
module key_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  assign o_q = r_q;
endmodule

// File: rtl/keypad_debounce_encoder.sv
// keypad_debounce_encoder: debounces ten digit keys, encodes presses, counts entry digits, times the beep
module keypad_debounce_encoder
  import keypad_debounce_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BEEP_CYCLES     = 2500000,
  parameter int ENTRY_DIGITS    = 4
) (
  input logic clk,
  input logic rst,
  keypad_debounce_encoder_if.slave kp
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  logic [NUM_KEYS-1:0] w_ks, r_snap, w_snap;
  logic [DW-1:0]       r_cnt, w_cnt;
  logic [BW-1:0]       r_beep;
  logic [3:0]          r_code;
  logic [2:0]          r_digit;
  logic                r_key_valid, r_err, r_done;
  logic                w_accept, w_err, w_last;
  state_t              r_state, w_state;
  onehot_t             w_oh;
  key_sync #(.W(NUM_KEYS)) u_sync (.clk(clk), .rst_n(rst), .i_d(kp.key_in), .o_q(w_ks));
  assign w_oh   = onehot_enc(r_snap);
  assign w_last = (r_digit == 3'(ENTRY_DIGITS - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_snap  <= w_snap;
      r_cnt   <= w_cnt;
    end
  // A vector change restarts the count; acceptance needs DEBOUNCE_CYCLES of the same vector
  always_comb begin
    w_state  = r_state;
    w_snap   = r_snap;
    w_cnt    = r_cnt;
    w_accept = 1'b0;
    w_err    = 1'b0;
    unique case (r_state)
      IDLE:
        if (w_ks != '0) begin
          w_snap  = w_ks;
          w_cnt   = DW'(1);
          w_state = SETTLE;
        end
      SETTLE:
        if (w_ks == '0) w_state = IDLE;
        else if (w_ks != r_snap) begin
          w_snap = w_ks;
          w_cnt  = DW'(1);
        end else if (r_cnt == DW'(DEBOUNCE_CYCLES)) begin
          w_accept = w_oh.ok;
          w_err    = !w_oh.ok;
          w_state  = HELD;
        end else w_cnt = r_cnt + DW'(1);
      HELD:
        if (w_ks == '0) begin
          w_cnt   = DW'(1);
          w_state = RELEASE;
        end
      RELEASE:
        if (w_ks != '0) w_state = HELD;
        else if (r_cnt == DW'(DEBOUNCE_CYCLES)) w_state = IDLE;
        else w_cnt = r_cnt + DW'(1);
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_code      <= KEY_NONE;
      r_digit     <= '0;
      r_beep      <= '0;
    end else begin
      r_key_valid <= w_accept;
      r_err       <= w_err;
      r_code      <= w_accept ? w_oh.idx : r_code;
      r_done      <= w_accept && w_last && !kp.clr;
      r_digit     <= kp.clr ? 3'd0 : w_accept ? (w_last ? 3'd0 : r_digit + 3'd1) : r_digit;
      r_beep      <= (w_accept || w_err) ? BW'(BEEP_CYCLES) : r_beep - BW'(r_beep != '0);
    end
  assign kp.key_valid     = r_key_valid;
  assign kp.multi_key_err = r_err;
  assign kp.entry_done    = r_done;
  assign kp.key_code      = r_code;
  assign kp.digit_cnt     = r_digit;
  assign kp.beep_en       = (r_beep != '0);
endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// tb_keypad_debounce_encoder: randomized presses scored against a timing-rule reference model
module tb_keypad_debounce_encoder;
  localparam int D = 4;
  localparam int B = 8;
  typedef struct {
    int         cyc;
    bit         err;
    logic [3:0] code;
    logic [2:0] digit;
    bit         done;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  ev_t  q[$];
  logic [3:0] model_code = 4'hF;
  int   model_digit = 0;
  int   beep_start = -1000;
  logic [3:0] cur_code = 4'hF;
  keypad_debounce_encoder_if kp();
  keypad_debounce_encoder #(.DEBOUNCE_CYCLES(D), .BEEP_CYCLES(B), .ENTRY_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .kp(kp)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // A press accepts D+2 edges after the edge that first samples the final stable vector
  task automatic expect_press(input logic [9:0] v, input int e, input bit coll, output int acc);
    ev_t ev;
    int n, idx;
    n = 0;
    idx = 0;
    for (int i = 0; i < 10; i++) if (v[i]) begin n++; idx = i; end
    acc = e + D + 2;
    ev.cyc = acc;
    ev.err = (n != 1);
    ev.done = 1'b0;
    if (n == 1) begin
      model_code = 4'(idx);
      if (coll) model_digit = 0;
      else if (model_digit == 3) begin model_digit = 0; ev.done = 1'b1; end
      else model_digit++;
    end
    ev.code = model_code;
    ev.digit = 3'(model_digit);
    q.push_back(ev);
  endtask
  task automatic seg(input logic [9:0] v, input int n);
    kp.key_in = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic final_press(input logic [9:0] v, input int hold, input bit coll);
    int acc;
    expect_press(v, cyc + 1, coll, acc);
    kp.key_in = v;
    for (int h = 0; h < hold; h++) begin
      if (coll) kp.clr = (cyc == acc - 1);
      @(negedge clk);
    end
    kp.clr = 1'b0;
  endtask
  task automatic release_rand(input logic [9:0] v);
    int nb;
    nb = $urandom_range(0, 2);
    for (int k = 0; k < nb; k++) begin
      seg(10'd0, $urandom_range(1, 2));
      seg(v, $urandom_range(1, 2));
    end
    seg(10'd0, D + 4);
  endtask
  task automatic clr_pulse();
    kp.clr = 1'b1;
    @(negedge clk);
    kp.clr = 1'b0;
    model_digit = 0;
  endtask
  task automatic press(input logic [9:0] v);
    final_press(v, D + 3, 1'b0);
    seg(10'd0, D + 4);
  endtask
  task automatic rst_pulse();
    #2 rst = 1'b0;
    #1;
    chk("rst_strobes", int'({kp.key_valid, kp.multi_key_err, kp.entry_done}), 0);
    chk("rst_key_code", int'(kp.key_code), 15);
    chk("rst_digit_cnt", int'(kp.digit_cnt), 0);
    chk("rst_beep_en", int'(kp.beep_en), 0);
    q.delete();
    model_code = 4'hF;
    model_digit = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask
  task automatic rand_press();
    logic [9:0] v;
    int i, j, nb;
    if ($urandom_range(0, 4) == 0) begin
      i = $urandom_range(0, 9);
      j = (i + 1 + $urandom_range(0, 8)) % 10;
      v = 10'($urandom_range(0, 1023));
      v[i] = 1'b1;
      v[j] = 1'b1;
    end else begin
      v = 10'd0;
      v[$urandom_range(0, 9)] = 1'b1;
    end
    nb = $urandom_range(0, 3);
    for (int k = 0; k < nb; k++) begin
      seg(10'($urandom_range(1, 1023)), $urandom_range(1, D));
      seg(10'd0, $urandom_range(1, D));
    end
    final_press(v, D + 1 + $urandom_range(0, 8), 1'b0);
    release_rand(v);
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (!rst) begin
        beep_start = -1000;
        cur_code = 4'hF;
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL missed_strobe: got none expected strobe at cycle %0d (now %0d)", q[0].cyc, cyc);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          beep_start = cyc;
          cur_code = e.code;
          chk("key_valid", int'(kp.key_valid), int'(!e.err));
          chk("multi_key_err", int'(kp.multi_key_err), int'(e.err));
          chk("digit_cnt", int'(kp.digit_cnt), int'(e.digit));
          chk("entry_done", int'(kp.entry_done), int'(e.done));
        end else chk("idle_strobes", int'({kp.key_valid, kp.multi_key_err, kp.entry_done}), 0);
        chk("key_code", int'(kp.key_code), int'(cur_code));
        chk("beep_en", int'(kp.beep_en), int'(cyc >= beep_start && cyc < beep_start + B));
      end
    end
  end
  initial begin
    int acc;
    kp.key_in = 10'd0;
    kp.clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_key_valid", int'(kp.key_valid), 0);
    chk("reset_key_code", int'(kp.key_code), 15);
    chk("reset_digit_cnt", int'(kp.digit_cnt), 0);
    chk("reset_beep_en", int'(kp.beep_en), 0);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    final_press(10'b0000100000, 20, 1'b0);
    seg(10'd0, D + 4);
    seg(10'b1000, 2);
    seg(10'd0, 1);
    final_press(10'b1000, 12, 1'b0);
    seg(10'd0, 1);
    seg(10'b1000, 1);
    seg(10'd0, D + 4);
    clr_pulse();
    for (int k = 1; k <= 4; k++) press(10'd1 << k);
    final_press(10'b0000000011, 10, 1'b0);
    seg(10'd0, D + 4);
    for (int k = 1; k <= 3; k++) press(10'd1 << k);
    final_press(10'b1000000000, D + 6, 1'b1);
    seg(10'd0, D + 4);
    kp.key_in = 10'b0010000000;
    repeat (3) @(negedge clk);
    rst_pulse();
    expect_press(10'b0010000000, cyc + 1, 1'b0, acc);
    while (cyc < acc + 2) @(negedge clk);
    seg(10'd0, D + 4);
    kp.key_in = 10'b0000000100;
    expect_press(10'b0000000100, cyc + 1, 1'b0, acc);
    while (cyc < acc + 3) @(negedge clk);
    rst_pulse();
    expect_press(10'b0000000100, cyc + 1, 1'b0, acc);
    while (cyc < acc + 2) @(negedge clk);
    seg(10'd0, D + 4);
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) clr_pulse();
      rand_press();
    end
    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
